// File: rtl/imem_loader_ctrl.sv
// Instruction-memory load sequencer: streams host words into imem from BASE_ADDR,
// then pulses core_start and hands the single imem port over to core fetch.
module imem_loader_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load_req_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              word_valid_i,
  input  logic [31:0]       word_data_i,
  output logic              word_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              core_fetch_req_i,
  input  logic [ADDR_W-1:0] core_fetch_addr_i,
  output logic              core_fetch_grant_o,
  output logic              core_stall_o,
  output logic              core_start_o,
  output logic              busy_o,
  output logic              len_err_o
);

  localparam logic [ADDR_W:0]   MAX_LEN = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_START, S_RUN} state_e;

  state_e            state_q;
  logic [ADDR_W:0]   count_q, len_q;
  logic              we_q, start_q, stall_q, busy_q, len_err_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              running, hs, len_ok;

  assign running = (state_q == S_RUN);
  assign hs      = word_valid_i & word_ready_o;
  assign len_ok  = (load_len_i != '0) && (load_len_i <= MAX_LEN);

  // Port mux: the core owns the address lines combinationally only while running.
  assign word_ready_o       = (state_q == S_LOAD);
  assign core_fetch_grant_o = running & core_fetch_req_i;
  assign mem_addr_o         = running ? core_fetch_addr_i : waddr_q;
  assign mem_we_o           = we_q;
  assign mem_wdata_o        = wdata_q;
  assign core_stall_o       = stall_q;
  assign core_start_o       = start_q;
  assign busy_o             = busy_q;
  assign len_err_o          = len_err_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      len_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      start_q   <= 1'b0;
      stall_q   <= 1'b1;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      we_q    <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RUN: begin
          if (load_req_i) begin
            if (len_ok) begin
              state_q   <= S_LOAD;
              count_q   <= '0;
              len_q     <= load_len_i;
              len_err_q <= 1'b0;
              stall_q   <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              len_err_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (hs) begin
            we_q    <= 1'b1;
            waddr_q <= BASE + count_q[ADDR_W-1:0];
            wdata_q <= word_data_i;
            count_q <= count_q + 1'b1;
            if ((count_q + 1'b1) == len_q) state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          state_q <= S_START;
          start_q <= 1'b1;
        end
        S_START: begin
          state_q <= S_RUN;
          stall_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Randomized + directed bench for imem_loader_ctrl; two instances (BASE 0 and 1022)
// share stimulus and are checked every cycle against an event-timeline model.
module tb_imem_loader_ctrl;

  localparam int INF = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        load_req = 1'b0;
  logic [10:0] load_len = '0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic        fetch_req = 1'b0;
  logic [9:0]  fetch_addr = '0;

  logic        ready[2], we[2], grant[2], stall[2], start[2], busy[2], lerr[2];
  logic [9:0]  maddr[2];
  logic [31:0] wdata[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    imem_loader_ctrl #(.ADDR_W(10), .MAX_WORDS(1024), .BASE_ADDR(g == 0 ? 0 : 1022)) u_dut (
      .clk(clk), .nrst(nrst),
      .load_req_i(load_req), .load_len_i(load_len),
      .word_valid_i(word_valid), .word_data_i(word_data), .word_ready_o(ready[g]),
      .mem_we_o(we[g]), .mem_addr_o(maddr[g]), .mem_wdata_o(wdata[g]),
      .core_fetch_req_i(fetch_req), .core_fetch_addr_i(fetch_addr),
      .core_fetch_grant_o(grant[g]), .core_stall_o(stall[g]), .core_start_o(start[g]),
      .busy_o(busy[g]), .len_err_o(lerr[g])
    );
  end

  int n_chk = 0, n_pass = 0;

  // Timeline model: each accepted word shows up as a write one cycle later; the
  // last handshake at cycle c gives FLUSH at c+1, start at c+2, run from c+3.
  int          cyc = 0;
  bit          active_load;
  int          words_left, next_idx, wr_cyc, start_cyc, run_from, last_idx;
  bit          last_v, m_err;
  logic [31:0] last_data;

  function automatic bit m_busy();
    return active_load || (start_cyc >= 0 && cyc >= start_cyc - 1 && cyc <= start_cyc);
  endfunction

  task automatic m_reset();
    active_load = 0; words_left = 0; next_idx = 0; wr_cyc = -1; start_cyc = -1;
    run_from = INF; last_v = 0; last_idx = 0; last_data = '0; m_err = 0;
  endtask

  task automatic m_update();
    if (!nrst) m_reset();
    else if (!m_busy() && load_req) begin
      if (load_len >= 1 && load_len <= 1024) begin
        active_load = 1; words_left = int'(load_len); next_idx = 0; m_err = 0;
        run_from = INF; start_cyc = -1;
      end else m_err = 1;
    end else if (active_load && word_valid) begin
      wr_cyc = cyc + 1; last_v = 1; last_idx = next_idx; last_data = word_data;
      next_idx++; words_left--;
      if (words_left == 0) begin
        active_load = 0; start_cyc = cyc + 2; run_from = cyc + 3;
      end
    end
    cyc++;
  endtask

  function automatic logic [31:0] exp_addr(int g);
    if (cyc >= run_from) return {22'd0, fetch_addr};
    if (!last_v) return 32'd0;
    return 32'(((g == 0 ? 0 : 1022) + last_idx) % 1024);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("ready%0d", g), 32'(ready[g]), 32'(active_load));
        chk($sformatf("we%0d", g), 32'(we[g]), 32'(cyc == wr_cyc));
        chk($sformatf("addr%0d", g), 32'(maddr[g]), exp_addr(g));
        chk($sformatf("wdata%0d", g), wdata[g], last_v ? last_data : 32'd0);
        chk($sformatf("grant%0d", g), 32'(grant[g]), 32'(cyc >= run_from && fetch_req));
        chk($sformatf("stall%0d", g), 32'(stall[g]), 32'(cyc < run_from));
        chk($sformatf("start%0d", g), 32'(start[g]), 32'(cyc == start_cyc));
        chk($sformatf("busy%0d", g), 32'(busy[g]), 32'(m_busy()));
        chk($sformatf("lenerr%0d", g), 32'(lerr[g]), 32'(m_err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic quiet();
    load_req = 0; load_len = '0; word_valid = 0; word_data = '0; fetch_req = 0; fetch_addr = '0;
  endtask

  task automatic lit_reset_vals(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_we"}, 32'(we[g]), 0);
      chk({tag, "_addr"}, 32'(maddr[g]), 0);
      chk({tag, "_wdata"}, wdata[g], 0);
      chk({tag, "_ready"}, 32'(ready[g]), 0);
      chk({tag, "_grant"}, 32'(grant[g]), 0);
      chk({tag, "_stall"}, 32'(stall[g]), 1);
      chk({tag, "_start"}, 32'(start[g]), 0);
      chk({tag, "_busy"}, 32'(busy[g]), 0);
      chk({tag, "_lenerr"}, 32'(lerr[g]), 0);
    end
  endtask

  task automatic do_reset();
    quiet();
    #2 nrst = 0;
    #1 lit_reset_vals("rst");
    m_reset();
    tick(); tick();
    nrst = 1;
  endtask

  logic [31:0] prog[3];

  initial begin
    prog[0] = 32'h00000013; prog[1] = 32'h002081B3; prog[2] = 32'h0000006F;
    m_reset();
    quiet();
    tick(); tick();
    nrst = 1;
    lit_reset_vals("init");

    // Three-word program, valid every cycle.
    load_req = 1; load_len = 11'd3; tick();
    load_req = 0; word_valid = 1; word_data = prog[0]; tick();
    word_data = prog[1];
    @(negedge clk);
    chk("t1_we0", 32'(we[0]), 1); chk("t1_addr0", 32'(maddr[0]), 0); chk("t1_data0", wdata[0], prog[0]);
    chk("t1_wrap_addr0", 32'(maddr[1]), 1022);
    tick(); word_data = prog[2];
    @(negedge clk);
    chk("t1_addr1", 32'(maddr[0]), 1); chk("t1_data1", wdata[0], prog[1]);
    chk("t1_wrap_addr1", 32'(maddr[1]), 1023);
    tick(); word_valid = 0;
    @(negedge clk);
    chk("t1_we2", 32'(we[0]), 1); chk("t1_addr2", 32'(maddr[0]), 2); chk("t1_data2", wdata[0], prog[2]);
    chk("t1_wrap_addr2", 32'(maddr[1]), 0);
    chk("t1_ready_flush", 32'(ready[0]), 0); chk("t1_start_flush", 32'(start[0]), 0);
    tick();
    @(negedge clk);
    chk("t1_start", 32'(start[0]), 1); chk("t1_stall_start", 32'(stall[0]), 1); chk("t1_we_start", 32'(we[0]), 0);
    tick();
    @(negedge clk);
    chk("t1_start_off", 32'(start[0]), 0); chk("t1_stall_run", 32'(stall[0]), 0); chk("t1_busy_run", 32'(busy[0]), 0);

    // Fetch in RUN, then reload of two words.
    fetch_req = 1; fetch_addr = 10'h005;
    @(negedge clk);
    chk("t4_grant", 32'(grant[0]), 1); chk("t4_addr", 32'(maddr[0]), 5); chk("t4_addr_b", 32'(maddr[1]), 5);
    tick();
    load_req = 1; load_len = 11'd2;
    @(negedge clk);
    chk("t4_grant_reqcyc", 32'(grant[0]), 1);
    tick(); load_req = 0;
    @(negedge clk);
    chk("t4_grant_off", 32'(grant[0]), 0); chk("t4_stall_on", 32'(stall[0]), 1);
    word_valid = 1; word_data = 32'hA5A5_0001; tick();
    word_data = 32'hA5A5_0002; tick();
    word_valid = 0; fetch_req = 0;
    repeat (4) tick();

    // Four words with valid toggling; BASE 1022 instance wraps to 0,1.
    load_req = 1; load_len = 11'd4; tick(); load_req = 0;
    for (int i = 0; i < 8; i++) begin
      word_valid = (i % 2 == 0); word_data = 32'h1000 + i; tick();
    end
    word_valid = 0;
    repeat (4) tick();

    // Length rejections from IDLE.
    do_reset();
    load_req = 1; load_len = 11'd0; tick();
    load_len = 11'd1025;
    @(negedge clk);
    chk("t3_lenerr0", 32'(lerr[0]), 1); chk("t3_busy0", 32'(busy[0]), 0);
    tick(); load_req = 0;
    @(negedge clk);
    chk("t3_lenerr1025", 32'(lerr[0]), 1); chk("t3_we", 32'(we[0]), 0); chk("t3_ready", 32'(ready[0]), 0);
    tick();
    load_req = 1; load_len = 11'd1; tick();
    load_req = 0; word_valid = 1; word_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t3_lenerr_clr", 32'(lerr[0]), 0); chk("t3_busy", 32'(busy[0]), 1);
    tick(); word_valid = 0;
    repeat (4) tick();

    // Asynchronous reset after two of five words, then a clean reload.
    load_req = 1; load_len = 11'd5; tick();
    load_req = 0; word_valid = 1; word_data = 32'h55; tick();
    word_data = 32'h66; tick();
    do_reset();
    repeat (3) tick();
    load_req = 1; load_len = 11'd5; tick();
    load_req = 0;
    for (int i = 0; i < 5; i++) begin
      word_valid = 1; word_data = 32'h7000 + i; tick();
    end
    word_valid = 0;
    repeat (4) tick();

    // Full-size load.
    load_req = 1; load_len = 11'd1024; tick();
    load_req = 0; word_valid = 1;
    for (int i = 0; i < 1024; i++) begin
      word_data = $urandom; tick();
    end
    word_valid = 0;
    repeat (4) tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      load_req = ($urandom_range(0, 11) == 0);
      r = int'($urandom_range(0, 9));
      load_len = (r == 0) ? 11'd0 : (r == 1) ? 11'd1025 : 11'($urandom_range(1, 7));
      word_valid = ($urandom_range(0, 3) != 0);
      word_data = $urandom;
      fetch_req = $urandom_range(0, 1) == 1;
      fetch_addr = 10'($urandom);
      tick();
    end
    quiet();
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_loader_ctrl.md
Name: imem_loader_ctrl

Overview:
- Sequences program loading into the core's single-port instruction memory, then releases the core.
- Accepts 32-bit words from a debug/host source over a valid/ready stream and writes them to consecutive word addresses from BASE_ADDR.
- After the last write, pulses core_start once and hands the memory port to core fetch.
- Sole owner and arbiter of the imem port: loader in LOAD, core fetch in RUN.

Parameters:
ADDR_W, 10, instruction-memory word-address width
MAX_WORDS, 1024, largest legal load length; must be ≤ 2**ADDR_W
BASE_ADDR, 0, word address of the first loaded instruction

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
load_req  in  1  start a load session (level, sampled in IDLE and RUN)
load_len  in  ADDR_W+1  number of words to load, sampled with load_req
word_valid  in  1  source has a word
word_data  in  32  instruction word
word_ready  out  1  controller accepts word this cycle
mem_we  out  1  imem write enable
mem_addr  out  ADDR_W  imem address (write or fetch)
mem_wdata  out  32  imem write data
core_fetch_req  in  1  core fetch request
core_fetch_addr  in  ADDR_W  core fetch word address
core_fetch_grant  out  1  fetch granted this cycle
core_stall  out  1  core held (fetch/issue frozen)
core_start  out  1  one-cycle pulse: begin execution at BASE_ADDR
busy  out  1  high in LOAD, FLUSH, START
len_err  out  1  sticky: rejected load_len

Behaviour:
- Reset values: state IDLE, count 0, word_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_fetch_grant 0, core_stall 1, core_start 0, busy 0, len_err 0. Async reset mid-load aborts with no start pulse; written words stay in imem.
- States: IDLE, LOAD, FLUSH, START, RUN.
- IDLE: load_req with 1 ≤ load_len ≤ MAX_WORDS -> LOAD, count←0, len latched. Otherwise, with load_req high: stay IDLE, set len_err. len_err is cleared only by a subsequent accepted load_req.
- LOAD:
  - word_ready=1 combinationally.
  - Handshake = word_valid & word_ready.
  - On handshake, registered one cycle later: mem_we=1, mem_addr=(BASE_ADDR+count) mod 2**ADDR_W, mem_wdata=word_data; count increments.
  - No handshake: mem_we=0 next cycle.
  - Handshake of word len-1 -> FLUSH; word_ready falls that same cycle.
- FLUSH: one cycle; the last registered write is on the port. -> START.
- START: core_start=1 for exactly one cycle, core_stall still 1. -> RUN.
- RUN:
  - core_stall=0, mem_we=0.
  - mem_addr=core_fetch_addr and core_fetch_grant=core_fetch_req, both combinational, zero latency.
  - load_req in RUN: same accept/reject rules as IDLE. Accepted -> LOAD: core_stall=1 and grant=0 from the next cycle; a fetch in the request cycle is still granted. Rejected: stay RUN, set len_err.
- core_fetch_grant is 0 in every state except RUN; fetch requests outside RUN are dropped, not queued.
- Latency: the final write reaches the port 1 cycle after its handshake (FLUSH cycle); core_start follows 1 cycle later.
- Back-to-back: a handshake every cycle gives len consecutive mem_we cycles, addresses strictly incrementing.
- Address wrap: BASE_ADDR+count wraps modulo 2**ADDR_W, no error.
- load_len is ignored outside the accepting cycle.
- word_valid outside LOAD is ignored; nothing is consumed.

Test Plan:
- Reset, then load_req with load_len=3, words 0x00000013, 0x002081B3, 0x0000006F valid every cycle. Required: mem_we high 3 consecutive cycles at addr 0,1,2 with those data; core_start pulses 2 cycles after the third handshake; core_stall falls with the pulse+1.
- load_len=4 with word_valid toggled 1,0,1,0,… -> exactly 4 writes at addr 0..3 in order, no duplicates; mem_we low in gap cycles.
- load_len=0, then load_len=MAX_WORDS+1 -> len_err=1, state stays IDLE, no mem_we, no core_start. A following load_len=1 clears len_err and completes.
- In RUN: core_fetch_req=1, addr=0x005 -> same-cycle grant=1, mem_addr=0x005. Then load_req with len 2 -> stall=1 and grant=0 from the next cycle; reload writes addr 0,1; core_start pulses again.
- BASE_ADDR=1022, ADDR_W=10, load_len=4 -> writes at 1022, 1023, 0, 1.
- Assert nrst low after 2 of 5 words -> all outputs at reset values asynchronously; core_stall=1, no core_start. A new load of 5 then succeeds.
